// File: rtl/if_id_pipe_reg.sv
// -----------------------------------------------------------------------------
// if_id_pipe_reg
// IF->ID pipeline register. Captures fetch-stage PC+4 and instruction on every
// rising edge and presents them to decode one cycle later. Supports freeze
// (hazard stall), flush (branch taken, inserts a bubble), a valid bit marking
// bubbles, and saturating stall/flush/issue counters for performance debug.
//
// Ports
//   clk             in   1      clock, rising edge
//   rst             in   1      asynchronous reset, active-low
//   freeze          in   1      hold current contents
//   flush           in   1      discard the instruction being captured
//   if_pc           in   32     PC+4 from fetch
//   if_instruction  in   32     instruction from fetch
//   id_pc           out  32     registered PC+4 for decode
//   id_instruction  out  32     registered instruction, NOP_INSTR when bubble
//   id_valid        out  1      id_instruction is a real fetched instruction
//   stall_cnt       out  CNT_W  edges with freeze=1, flush=0
//   flush_cnt       out  CNT_W  edges with flush=1
//   issue_cnt       out  CNT_W  instructions loaded for decode
//
// State table
//   state    | meaning
//   ST_EMPTY | bubble in the register, id_valid=0
//   ST_FULL  | real instruction present, id_valid=1
//   ST_HELD  | real instruction present and frozen, id_valid=1
// -----------------------------------------------------------------------------
module if_id_pipe_reg #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flush,
    input  logic [31:0]      if_pc,
    input  logic [31:0]      if_instruction,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_instruction,
    output logic             id_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] issue_cnt
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_HELD  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       do_flush;
    logic       do_stall;
    logic       do_load;

    // flush outranks freeze, freeze outranks load
    assign do_flush = flush;
    assign do_stall = freeze & ~flush;
    assign do_load  = ~freeze & ~flush;

    always_comb begin
        state_d = state_q;
        if (do_flush) begin
            state_d = ST_EMPTY;
        end else if (do_stall) begin
            case (state_q)
                ST_FULL:  state_d = ST_HELD;
                ST_HELD:  state_d = ST_HELD;
                default:  state_d = ST_EMPTY;
            endcase
        end else begin
            state_d = ST_FULL;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // id_valid comes straight from the state register, so there is still no
    // combinational path from any input to any output.
    assign id_valid = (state_q != ST_EMPTY);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_pc          <= 32'h0000_0000;
            id_instruction <= NOP_INSTR;
        end else if (do_flush) begin
            // PC is kept on flush so the squashed address is visible for debug
            id_pc          <= if_pc;
            id_instruction <= NOP_INSTR;
        end else if (do_load) begin
            id_pc          <= if_pc;
            id_instruction <= if_instruction;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            issue_cnt <= '0;
        end else begin
            if (do_stall && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (do_flush && flush_cnt != CNT_MAX) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
            if (do_load && issue_cnt != CNT_MAX) begin
                issue_cnt <= issue_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_if_id_pipe_reg.sv
module tb_if_id_pipe_reg;

    localparam logic [31:0] NOP_A = 32'h0000_0000;
    localparam logic [31:0] NOP_B = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] if_pc = '0;
    logic [31:0] if_instruction = '0;

    logic [31:0] id_pc, id_instruction;
    logic        id_valid;
    logic [15:0] stall_cnt, flush_cnt, issue_cnt;

    logic [31:0] id_pc4, id_instruction4;
    logic        id_valid4;
    logic [3:0]  stall_cnt4, flush_cnt4, issue_cnt4;

    if_id_pipe_reg #(.NOP_INSTR(NOP_A), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .if_pc(if_pc), .if_instruction(if_instruction),
        .id_pc(id_pc), .id_instruction(id_instruction), .id_valid(id_valid),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .issue_cnt(issue_cnt)
    );

    if_id_pipe_reg #(.NOP_INSTR(NOP_B), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .if_pc(if_pc), .if_instruction(if_instruction),
        .id_pc(id_pc4), .id_instruction(id_instruction4), .id_valid(id_valid4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4), .issue_cnt(issue_cnt4)
    );

    always #5 clk = ~clk;

    // reference model: what decode should be seeing, counters kept unbounded
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        valid;
        int          st;
        int          fl;
        int          is;
    } exp_t;

    exp_t exp_q[$];
    exp_t m;
    bit   started = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [31:0] sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m.pc = '0; m.ins = '0; m.valid = 1'b0; m.st = 0; m.fl = 0; m.is = 0;
    endtask

    task automatic push_exp();
        exp_q.push_back(m);
        started = 1;
    endtask

    // one clock: drive inputs at negedge, predict the state after the next posedge
    task automatic step(input logic r, input logic fz, input logic fl,
                        input logic [31:0] pc, input logic [31:0] ins);
        @(negedge clk);
        rst = r; freeze = fz; flush = fl; if_pc = pc; if_instruction = ins;
        if (!r) begin
            model_reset();
        end else if (fl) begin
            m.pc = pc; m.valid = 1'b0; m.fl++;
        end else if (fz) begin
            m.st++;
        end else begin
            m.pc = pc; m.ins = ins; m.valid = 1'b1; m.is++;
        end
        push_exp();
    endtask

    // reset asserted between edges, with freeze/flush active to show they are ignored
    task automatic async_reset();
        @(posedge clk);
        #2;
        freeze = 1'b1; flush = 1'b1;
        rst = 1'b0;
        model_reset();
        push_exp();
    endtask

    // monitor: compare on every clock edge and on every reset assertion
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge rst);
            #1;
            if (exp_q.size() == 0) begin
                if (started) chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("id_pc",           id_pc,           e.pc);
                chk("id_instruction",  id_instruction,  e.valid ? e.ins : NOP_A);
                chk("id_valid",        {31'd0, id_valid}, {31'd0, e.valid});
                chk("stall_cnt",       {16'd0, stall_cnt}, sat(e.st, 65535));
                chk("flush_cnt",       {16'd0, flush_cnt}, sat(e.fl, 65535));
                chk("issue_cnt",       {16'd0, issue_cnt}, sat(e.is, 65535));
                chk("id_pc4",          id_pc4,          e.pc);
                chk("id_instruction4", id_instruction4, e.valid ? e.ins : NOP_B);
                chk("id_valid4",       {31'd0, id_valid4}, {31'd0, e.valid});
                chk("stall_cnt4",      {28'd0, stall_cnt4}, sat(e.st, 15));
                chk("flush_cnt4",      {28'd0, flush_cnt4}, sat(e.fl, 15));
                chk("issue_cnt4",      {28'd0, issue_cnt4}, sat(e.is, 15));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic fz, fl;
        model_reset();
        // held in reset across edges
        step(0, 1, 0, 32'h100, 32'hDEAD_BEEF);
        step(0, 0, 1, 32'h104, 32'hDEAD_BEEF);
        // stream of three instructions
        step(1, 0, 0, 32'd4,  32'hAAAA_0001);
        step(1, 0, 0, 32'd8,  32'hBBBB_0002);
        step(1, 0, 0, 32'd12, 32'hCCCC_0003);
        // load 8/B then freeze three cycles with new inputs, then release
        step(1, 0, 0, 32'd8,  32'hBBBB_0002);
        step(1, 1, 0, 32'd16, 32'h1111_1111);
        step(1, 1, 0, 32'd20, 32'h2222_2222);
        step(1, 1, 0, 32'd24, 32'h3333_3333);
        step(1, 0, 0, 32'd28, 32'h4444_4444);
        // flush, then flush+freeze together
        step(1, 0, 1, 32'h40, 32'hDDDD_0004);
        step(1, 0, 0, 32'h44, 32'h5555_5555);
        step(1, 1, 1, 32'h48, 32'h6666_6666);
        // freeze while empty stays empty
        step(1, 1, 0, 32'h4C, 32'h7777_7777);
        step(1, 0, 0, 32'h50, 32'h8888_8888);
        // long freeze saturates the 4-bit stall counter
        for (int i = 0; i < 20; i++) step(1, 1, 0, 32'h200 + 4 * i, $urandom);
        step(1, 0, 0, 32'h300, 32'h9999_9999);
        // asynchronous reset mid-cycle with non-zero counters
        async_reset();
        step(0, 1, 1, 32'h400, 32'hABCD_0000);
        step(1, 0, 0, 32'h404, 32'hABCD_0001);
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                async_reset();
                step(0, 1'($urandom), 1'($urandom), $urandom, $urandom);
            end else begin
                fz = ($urandom_range(0, 99) < 30);
                fl = ($urandom_range(0, 99) < 12);
                step(1, fz, fl, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom);
            end
        end
        @(posedge clk);
        #3;
        chk("sb_drain", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
